// File: rtl/tdc_readout_pkg.sv
// +----------------------------------------------------------------------------+
// | tdc_readout_pkg : hit-word field widths, bit offsets and packing helper     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package tdc_readout_pkg;

  localparam int TOA_W  = 10;
  localparam int TOT_W  = 9;
  localparam int CAL_W  = 10;
  localparam int BCID_W = 12;

  localparam int TOA_LSB    = 0;
  localparam int TOT_LSB    = TOA_LSB + TOA_W;
  localparam int CAL_LSB    = TOT_LSB + TOT_W;
  localparam int TOAERR_BIT = CAL_LSB + CAL_W;
  localparam int TOTERR_BIT = TOAERR_BIT + 1;
  localparam int CALERR_BIT = TOTERR_BIT + 1;
  localparam int BCID_LSB   = CALERR_BIT + 1;
  localparam int HIT_WORD_W = BCID_LSB + BCID_W;

  localparam int BCID_MAX_DEFAULT = 3563;

  function automatic logic [HIT_WORD_W-1:0] pack_hit(
    input logic [BCID_W-1:0] bcid,
    input logic              cal_err,
    input logic              tot_err,
    input logic              toa_err,
    input logic [CAL_W-1:0]  cal,
    input logic [TOT_W-1:0]  tot,
    input logic [TOA_W-1:0]  toa
  );
    logic [HIT_WORD_W-1:0] w;
    w                       = '0;
    w[TOA_LSB +: TOA_W]     = toa;
    w[TOT_LSB +: TOT_W]     = tot;
    w[CAL_LSB +: CAL_W]     = cal;
    w[TOAERR_BIT]           = toa_err;
    w[TOTERR_BIT]           = tot_err;
    w[CALERR_BIT]           = cal_err;
    w[BCID_LSB +: BCID_W]   = bcid;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdc_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | tdc_sync_fifo : single-clock first-word-fall-through FIFO with occupancy    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tdc_sync_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_req,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_ready,
  output logic                     o_rd_valid,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam int              c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [c_AW-1:0]  w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == c_FULL);
  assign w_pop        = ~w_empty & i_rd_ready;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_push       = i_wr_req & (~w_full | w_pop);
  assign w_rd_ptr_nxt = r_rd_ptr + c_AW'(1);

  // The head register is the FWFT output; it keeps the last popped word once empty.
  always_comb begin
    w_head_nxt = r_head;
    if (w_pop) begin
      if (r_count > c_ONE) begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end else if (w_push) begin
        w_head_nxt = i_wr_data;
      end
    end else if (w_empty && w_push) begin
      w_head_nxt = i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_valid = ~w_empty;
  assign o_rd_data  = r_head;
  assign o_count    = r_count;
  assign o_drop     = i_wr_req & ~w_push;

endmodule

`default_nettype wire

// File: rtl/tdc_hit_buffer.sv
// +----------------------------------------------------------------------------+
// | tdc_hit_buffer : BCID tagging, hit packing and overflow-counted FWFT buffer |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tdc_hit_buffer
  import tdc_readout_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int BCID_MAX = BCID_MAX_DEFAULT,
  parameter int OVF_W    = 8
) (
  input  logic                    clk40M,
  input  logic                    rstn,
  input  logic                    hitFlag,
  input  logic [TOA_W-1:0]        TOA_code,
  input  logic [TOT_W-1:0]        TOT_code,
  input  logic [CAL_W-1:0]        Cal_code,
  input  logic                    TOAerrorFlag,
  input  logic                    TOTerrorFlag,
  input  logic                    CalerrorFlag,
  input  logic                    bcReset,
  input  logic                    rdReady,
  output logic                    rdValid,
  output logic [HIT_WORD_W-1:0]   rdData,
  output logic [$clog2(DEPTH):0]  fifoCount,
  output logic [OVF_W-1:0]        overflowCnt,
  output logic                    overflowFlag,
  input  logic                    clrOverflow
);

  localparam logic [BCID_W-1:0] c_BCID_MAX = BCID_W'(BCID_MAX);

  logic [BCID_W-1:0]     r_bcid;
  logic [OVF_W-1:0]      r_ovf_cnt;
  logic                  r_ovf_flag;
  logic [HIT_WORD_W-1:0] w_hit_word;
  logic                  w_drop;

  // Hits take the BCID of their own cycle, so the tag comes straight from the register.
  assign w_hit_word = pack_hit(r_bcid, CalerrorFlag, TOTerrorFlag, TOAerrorFlag,
                               Cal_code, TOT_code, TOA_code);

  always_ff @(posedge clk40M or negedge rstn) begin
    if (!rstn) begin
      r_bcid <= '0;
    end else if (bcReset || (r_bcid == c_BCID_MAX)) begin
      r_bcid <= '0;
    end else begin
      r_bcid <= r_bcid + BCID_W'(1);
    end
  end

  tdc_sync_fifo #(
    .WIDTH (HIT_WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk40M),
    .rst_n      (rstn),
    .i_wr_req   (hitFlag),
    .i_wr_data  (w_hit_word),
    .i_rd_ready (rdReady),
    .o_rd_valid (rdValid),
    .o_rd_data  (rdData),
    .o_count    (fifoCount),
    .o_drop     (w_drop)
  );

  // Clear wins over a drop landing on the same edge.
  always_ff @(posedge clk40M or negedge rstn) begin
    if (!rstn) begin
      r_ovf_cnt  <= '0;
      r_ovf_flag <= 1'b0;
    end else if (clrOverflow) begin
      r_ovf_cnt  <= '0;
      r_ovf_flag <= 1'b0;
    end else if (w_drop) begin
      r_ovf_flag <= 1'b1;
      if (~&r_ovf_cnt) begin
        r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
      end
    end
  end

  assign overflowCnt  = r_ovf_cnt;
  assign overflowFlag = r_ovf_flag;

endmodule

`default_nettype wire

// File: tb/tb_tdc_hit_buffer.sv
// +----------------------------------------------------------------------------+
// | tb_tdc_hit_buffer : directed stimulus with queue scoreboard and monitor     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_tdc_hit_buffer;

  localparam int DEPTH = 16;

  logic        clk40M = 1'b0;
  logic        rstn;
  logic        hitFlag;
  logic [9:0]  TOA_code;
  logic [8:0]  TOT_code;
  logic [9:0]  Cal_code;
  logic        TOAerrorFlag, TOTerrorFlag, CalerrorFlag;
  logic        bcReset, rdReady, clrOverflow;
  logic        rdValid;
  logic [43:0] rdData;
  logic [4:0]  fifoCount;
  logic [7:0]  overflowCnt;
  logic        overflowFlag;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [43:0] q[$];
  int          m_bcid = 0;

  tdc_hit_buffer #(.DEPTH(DEPTH), .BCID_MAX(3563), .OVF_W(8)) dut (
    .clk40M(clk40M), .rstn(rstn), .hitFlag(hitFlag),
    .TOA_code(TOA_code), .TOT_code(TOT_code), .Cal_code(Cal_code),
    .TOAerrorFlag(TOAerrorFlag), .TOTerrorFlag(TOTerrorFlag), .CalerrorFlag(CalerrorFlag),
    .bcReset(bcReset), .rdReady(rdReady), .rdValid(rdValid), .rdData(rdData),
    .fifoCount(fifoCount), .overflowCnt(overflowCnt), .overflowFlag(overflowFlag),
    .clrOverflow(clrOverflow)
  );

  always #12.5 clk40M = ~clk40M;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the queue mirrors FIFO content between edges; a pop is checked the cycle it is presented.
  always @(negedge clk40M) begin
    if (rstn) begin
      chk("valid", 64'(rdValid), 64'(q.size() != 0));
      chk("count", 64'(fifoCount), 64'(q.size()));
      if (rdValid && rdReady && q.size() > 0) begin
        logic [43:0] e;
        e = q.pop_front();
        chk("data", 64'(rdData), 64'(e));
      end
    end
  end

  // Drive one cycle: inputs set just after an edge, expectation queued once the edge has taken it.
  task automatic step(input bit hit, input logic [9:0] toa, input logic [8:0] tot,
                      input logic [9:0] cal, input logic [2:0] err,
                      input bit bcr, input bit rdy, input bit clr);
    logic [43:0] w;
    bit          acc;
    hitFlag = hit; TOA_code = toa; TOT_code = tot; Cal_code = cal;
    {CalerrorFlag, TOTerrorFlag, TOAerrorFlag} = err;
    bcReset = bcr; rdReady = rdy; clrOverflow = clr;
    w   = {12'(m_bcid), err, cal, tot, toa};
    acc = hit && ((q.size() < DEPTH) || (q.size() > 0 && rdy));
    @(posedge clk40M); #1;
    if (acc) q.push_back(w);
    m_bcid = bcr ? 0 : ((m_bcid == 3563) ? 0 : m_bcid + 1);
  endtask

  task automatic idle(input bit rdy);
    step(0, 10'd0, 9'd0, 10'd0, 3'b000, 0, rdy, 0);
  endtask

  task automatic hit_n(input int n, input int seed);
    for (int i = 0; i < n; i++)
      step(1, 10'(seed + i * 37), 9'(seed * 3 + i * 11), 10'(1000 - i - seed), 3'(i), 0, 0, 0);
  endtask

  task automatic drain_all();
    for (int k = 0; k < 4 * DEPTH && q.size() > 0; k++) idle(1);
    chk("drained", 64'(rdValid), 64'd0);
  endtask

  task automatic wait_bcid(input int t);
    bit reached;
    reached = 0;
    for (int k = 0; k < 5000 && !reached; k++) begin
      if (m_bcid == t) reached = 1;
      else idle(0);
    end
    chk("wait_bcid_reached", 64'(reached), 64'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0; hitFlag = 1'b1; rdReady = 1'b1; clrOverflow = 1'b0; bcReset = 1'b0;
    q.delete();
    m_bcid = 0;
    repeat (3) @(posedge clk40M);
    #1;
    chk("rst_valid", 64'(rdValid), 64'd0);
    chk("rst_data", 64'(rdData), 64'd0);
    chk("rst_count", 64'(fifoCount), 64'd0);
    chk("rst_ovfcnt", 64'(overflowCnt), 64'd0);
    chk("rst_ovfflag", 64'(overflowFlag), 64'd0);
    rstn = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b0;
    rstn = 1'b1; hitFlag = 0; TOA_code = 0; TOT_code = 0; Cal_code = 0;
    TOAerrorFlag = 0; TOTerrorFlag = 0; CalerrorFlag = 0;
    bcReset = 0; rdReady = 0; clrOverflow = 0;
    #2;
    do_reset();

    // First edge after release samples BCID 0.
    step(1, 10'd1, 9'd2, 10'd3, 3'b000, 0, 0, 0);
    chk("first_valid", 64'(rdValid), 64'd1);
    chk("first_bcid", 64'(rdData[43:32]), 64'd0);
    hit_n(2, 5);

    // Reset with stored words discards them.
    do_reset();
    idle(1);
    chk("post_rst_valid", 64'(rdValid), 64'd0);

    // Single hit at BCID 5.
    wait_bcid(5);
    step(1, 10'd517, 9'd300, 10'd1023, 3'b001, 0, 0, 0);
    chk("single_valid", 64'(rdValid), 64'd1);
    chk("single_word", 64'(rdData), 64'({12'd5, 1'b0, 1'b0, 1'b1, 10'd1023, 9'd300, 10'd517}));
    idle(1);
    chk("single_popped", 64'(rdValid), 64'd0);

    // Fill plus three drops, then in-order drain.
    b0 = m_bcid;
    hit_n(16, 40);
    hit_n(3, 90);
    chk("fill_count", 64'(fifoCount), 64'd16);
    chk("fill_ovfcnt", 64'(overflowCnt), 64'd3);
    chk("fill_ovfflag", 64'(overflowFlag), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_bcid", 64'(rdData[43:32]), 64'(b0 + i));
      idle(1);
    end
    chk("drain_empty", 64'(rdValid), 64'd0);

    // Full with simultaneous push/pop.
    step(0, 10'd0, 9'd0, 10'd0, 3'b000, 0, 0, 1);
    chk("clr_ovfcnt", 64'(overflowCnt), 64'd0);
    chk("clr_ovfflag", 64'(overflowFlag), 64'd0);
    hit_n(16, 200);
    b0 = m_bcid;
    step(1, 10'd777, 9'd111, 10'd222, 3'b111, 0, 1, 0);
    chk("fullpp_count", 64'(fifoCount), 64'd16);
    chk("fullpp_ovfcnt", 64'(overflowCnt), 64'd0);
    chk("fullpp_ovfflag", 64'(overflowFlag), 64'd0);
    for (int i = 0; i < 15; i++) idle(1);
    chk("fullpp_last_bcid", 64'(rdData[43:32]), 64'(b0));
    chk("fullpp_last_toa", 64'(rdData[9:0]), 64'd777);
    idle(1);
    chk("fullpp_empty", 64'(rdValid), 64'd0);

    // BCID wrap.
    wait_bcid(3563);
    step(1, 10'd11, 9'd12, 10'd13, 3'b010, 0, 0, 0);
    step(1, 10'd21, 9'd22, 10'd23, 3'b100, 0, 0, 0);
    chk("wrap_tag_max", 64'(rdData[43:32]), 64'd3563);
    idle(1);
    chk("wrap_tag_zero", 64'(rdData[43:32]), 64'd0);
    idle(1);
    chk("wrap_empty", 64'(rdValid), 64'd0);

    // bcReset coincident with a hit.
    wait_bcid(100);
    step(1, 10'd31, 9'd32, 10'd33, 3'b000, 1, 0, 0);
    idle(0);
    step(1, 10'd41, 9'd42, 10'd43, 3'b000, 0, 0, 0);
    chk("bcr_tag_100", 64'(rdData[43:32]), 64'd100);
    idle(1);
    chk("bcr_tag_1", 64'(rdData[43:32]), 64'd1);
    idle(1);

    // Saturation, then clear coincident with a drop.
    hit_n(16, 300);
    hit_n(300, 7);
    chk("sat_ovfcnt", 64'(overflowCnt), 64'd255);
    chk("sat_ovfflag", 64'(overflowFlag), 64'd1);
    step(1, 10'd5, 9'd6, 10'd7, 3'b000, 0, 0, 1);
    chk("clrdrop_ovfcnt", 64'(overflowCnt), 64'd0);
    chk("clrdrop_ovfflag", 64'(overflowFlag), 64'd0);
    drain_all();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
